// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants and types for the 4-digit 7-segment display path.
//   SEG7_DIGITS              - number of multiplexed digits
//   SEG7_NIBBLE_W            - bits per displayed digit value
//   SEG7_REFRESH_DIV_DEFAULT - default clock cycles per digit (100 MHz -> 1 kHz)
//   seg7_idx_t               - digit index type
package seg7_pkg;

  localparam int SEG7_DIGITS              = 4;
  localparam int SEG7_NIBBLE_W            = 4;
  localparam int SEG7_REFRESH_DIV_DEFAULT = 100000;

  typedef logic [1:0] seg7_idx_t;

endpackage : seg7_pkg

// File: rtl/refresh_tick_gen.sv
// refresh_tick_gen
// Free-running prescaler that counts 0..REFRESH_DIV-1 and wraps. o_tick is
// high (combinationally) during the last count of each period, so a consumer
// that advances on o_tick changes state once every REFRESH_DIV edges.
// Ports:
//   i_clk  - clock
//   i_rst  - asynchronous active-high reset (counter to 0)
//   o_tick - one-cycle-wide strobe, high while the counter is at REFRESH_DIV-1
module refresh_tick_gen #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tick;

  assign w_tick = (r_cnt == LAST);
  assign o_tick = w_tick;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule : refresh_tick_gen

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexing scan driver for a 4-digit 7-segment display. Steps the
// active digit every REFRESH_DIV cycles and presents index, nibble and dot to
// the downstream decoder. Loaded values are held pending and only swapped into
// the displayed registers at a frame boundary (tick while digit 3 is active),
// so a frame never mixes old and new digits.
// Ports:
//   CLK            - clock
//   RESET          - asynchronous active-high reset
//   DATA_IN[15:0]  - value; nibble n drives digit n (digit 0 rightmost)
//   DOTS_IN[3:0]   - decimal points; bit n drives digit n, 1 = lit
//   LOAD_IN        - one-cycle capture strobe for DATA_IN/DOTS_IN
//   SEG_SELECT_OUT - active digit index
//   BIN_OUT[3:0]   - nibble of the active digit
//   DOT_OUT        - dot of the active digit
//   FRAME_OUT      - one-cycle pulse after each wrap from digit 3 to digit 0
//
// LOAD_IN protocol: there is no ready/backpressure. Every cycle with LOAD_IN
// high is a complete load; a later load before the boundary replaces an
// earlier one, and a load in the boundary cycle itself is shown immediately.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = SEG7_REFRESH_DIV_DEFAULT
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [15:0] DATA_IN,
  input  logic [3:0]  DOTS_IN,
  input  logic        LOAD_IN,
  output logic [1:0]  SEG_SELECT_OUT,
  output logic [3:0]  BIN_OUT,
  output logic        DOT_OUT,
  output logic        FRAME_OUT
);

  logic        w_tick;
  logic        w_boundary;
  seg7_idx_t   w_dig_next;
  logic [15:0] w_show_data_next;
  logic [3:0]  w_show_dots_next;
  logic [15:0] w_pend_data_next;
  logic [3:0]  w_pend_dots_next;
  logic        w_pend_vld_next;
  logic [3:0]  w_bin_next;
  logic        w_dot_next;

  seg7_idx_t   r_dig;
  logic [15:0] r_show_data;
  logic [3:0]  r_show_dots;
  logic [15:0] r_pend_data;
  logic [3:0]  r_pend_dots;
  logic        r_pend_vld;
  logic [3:0]  r_bin;
  logic        r_dot;
  logic        r_frame;

  refresh_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .i_clk (CLK),
    .i_rst (RESET),
    .o_tick(w_tick)
  );

  always_comb begin
    w_boundary       = w_tick && (r_dig == seg7_idx_t'(SEG7_DIGITS - 1));
    w_dig_next       = w_tick ? r_dig + seg7_idx_t'(1) : r_dig;
    w_show_data_next = r_show_data;
    w_show_dots_next = r_show_dots;
    w_pend_data_next = r_pend_data;
    w_pend_dots_next = r_pend_dots;
    w_pend_vld_next  = r_pend_vld;

    if (LOAD_IN && w_boundary) begin
      // Load lands exactly on the frame edge: bypass the pending stage.
      w_show_data_next = DATA_IN;
      w_show_dots_next = DOTS_IN;
      w_pend_vld_next  = 1'b0;
    end else if (w_boundary && r_pend_vld) begin
      w_show_data_next = r_pend_data;
      w_show_dots_next = r_pend_dots;
      w_pend_vld_next  = 1'b0;
    end else if (LOAD_IN) begin
      w_pend_data_next = DATA_IN;
      w_pend_dots_next = DOTS_IN;
      w_pend_vld_next  = 1'b1;
    end

    // Outputs are fed from next-state values so index, nibble and dot all
    // change on the same edge.
    w_bin_next = w_show_data_next[SEG7_NIBBLE_W*w_dig_next +: SEG7_NIBBLE_W];
    w_dot_next = w_show_dots_next[w_dig_next];
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_dig       <= '0;
      r_show_data <= '0;
      r_show_dots <= '0;
      r_pend_data <= '0;
      r_pend_dots <= '0;
      r_pend_vld  <= 1'b0;
      r_bin       <= '0;
      r_dot       <= 1'b0;
      r_frame     <= 1'b0;
    end else begin
      r_dig       <= w_dig_next;
      r_show_data <= w_show_data_next;
      r_show_dots <= w_show_dots_next;
      r_pend_data <= w_pend_data_next;
      r_pend_dots <= w_pend_dots_next;
      r_pend_vld  <= w_pend_vld_next;
      r_bin       <= w_bin_next;
      r_dot       <= w_dot_next;
      r_frame     <= w_boundary;
    end
  end

  assign SEG_SELECT_OUT = r_dig;
  assign BIN_OUT        = r_bin;
  assign DOT_OUT        = r_dot;
  assign FRAME_OUT      = r_frame;

endmodule : seg7_scan_driver

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Bench for seg7_scan_driver with REFRESH_DIV = 4. A behavioural model tracks
// the number of edges since reset release, derives the active digit and frame
// pulse arithmetically, and keeps the latest not-yet-shown load in a queue.
module tb_seg7_scan_driver;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  dots_in;
  logic        load_in;
  logic [1:0]  seg_sel;
  logic [3:0]  bin_out;
  logic        dot_out;
  logic        frame_out;

  int errors = 0;
  int checks = 0;

  // Model state
  int          edges;       // rising edges since reset release
  logic [15:0] shown_data;
  logic [3:0]  shown_dots;
  logic [19:0] exp_q[$];    // pending load {dots, data}; at most one entry

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  seg7_scan_driver #(
    .REFRESH_DIV(DIV)
  ) dut (
    .CLK           (clk),
    .RESET         (rst),
    .DATA_IN       (data_in),
    .DOTS_IN       (dots_in),
    .LOAD_IN       (load_in),
    .SEG_SELECT_OUT(seg_sel),
    .BIN_OUT       (bin_out),
    .DOT_OUT       (dot_out),
    .FRAME_OUT     (frame_out)
  );

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t edges=%0d)", tag, got, exp, $time, edges);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_seg"},   32'(seg_sel),   32'd0);
    check_eq({tag, "_bin"},   32'(bin_out),   32'd0);
    check_eq({tag, "_dot"},   32'(dot_out),   32'd0);
    check_eq({tag, "_frame"}, 32'(frame_out), 32'd0);
  endtask

  task automatic model_reset();
    edges      = 0;
    shown_data = '0;
    shown_dots = '0;
    exp_q.delete();
  endtask

  // Model of one rising edge given the inputs sampled on it.
  task automatic model_edge(input logic ld, input logic [15:0] d, input logic [3:0] dt);
    bit boundary;
    logic [19:0] p;
    boundary = ((edges % FRAME) == FRAME - 1);
    if (ld && boundary) begin
      exp_q.delete();
      shown_data = d;
      shown_dots = dt;
    end else if (boundary && exp_q.size() > 0) begin
      p = exp_q.pop_front();
      shown_data = p[15:0];
      shown_dots = p[19:16];
    end else if (ld) begin
      exp_q.delete();
      exp_q.push_back({dt, d});
    end
    edges++;
  endtask

  task automatic check_outputs();
    int dig;
    dig = (edges / DIV) % 4;
    check_eq("seg",   32'(seg_sel),   32'(dig));
    check_eq("bin",   32'(bin_out),   32'((shown_data >> (4 * dig)) & 16'hF));
    check_eq("dot",   32'(dot_out),   32'(shown_dots[dig]));
    check_eq("frame", 32'(frame_out), 32'((edges % FRAME) == 0));
  endtask

  // ---------------- driver ----------------
  // Drives inputs for the coming edge, waits for it, updates the model and
  // checks outputs 1 time unit after the edge.
  task automatic do_cycle(input logic ld, input logic [15:0] d, input logic [3:0] dt);
    load_in = ld;
    data_in = d;
    dots_in = dt;
    @(posedge clk);
    model_edge(ld, d, dt);
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(1'b0, $urandom(), 4'($urandom()));
  endtask

  // Idle until the next edge to be taken has pre-edge phase `ph` in the frame.
  task automatic idle_to_phase(input int ph);
    while ((edges % FRAME) != ph) do_cycle(1'b0, $urandom(), 4'($urandom()));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b1;
    load_in = 1'b0;
    data_in = '0;
    dots_in = '0;
    model_reset();
    #3;
    check_all_zero("reset");
    #9;
    rst = 1'b0;

    // Reset and scan: DATA 0, two frames
    for (int i = 0; i < 2 * FRAME; i++) do_cycle(1'b0, 16'h0000, 4'h0);

    // Deferred load while digit 1 active
    idle_to_phase(5);
    do_cycle(1'b1, 16'h1234, 4'h0);
    idle(FRAME + 4);

    // Last write wins within one frame
    idle_to_phase(2);
    do_cycle(1'b1, 16'hAAAA, 4'h0);
    idle(3);
    do_cycle(1'b1, 16'h5A5A, 4'h0);
    idle(FRAME + 2);

    // Coincident load on the boundary tick
    idle_to_phase(FRAME - 1);
    do_cycle(1'b1, 16'hBEEF, 4'h0);
    check_eq("coincident_bin", 32'(bin_out), 32'hF);
    check_eq("coincident_seg", 32'(seg_sel), 32'h0);
    idle(FRAME);

    // Dots
    idle_to_phase(7);
    do_cycle(1'b1, 16'h0F0F, 4'b0101);
    idle(2 * FRAME);

    // Held LOAD_IN: last cycle's value wins
    idle_to_phase(3);
    for (int i = 0; i < 5; i++) do_cycle(1'b1, 16'h1111 * 16'(i + 1), 4'(i));
    idle(FRAME + 2);

    // Asynchronous reset while digit 2 active with a load pending
    idle_to_phase(9);
    do_cycle(1'b1, 16'hCAFE, 4'hF);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    check_all_zero("held_rst");
    #3;
    rst = 1'b0;
    model_reset();
    idle(2 * FRAME);

    // Randomised phase
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        do_cycle(1'b1, 16'($urandom()), 4'($urandom()));
      else
        do_cycle(1'b0, 16'($urandom()), 4'($urandom()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_seg7_scan_driver
